mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 16, word address width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum BUSY cycles before an access is aborted (range 2..255).
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port req  in  2  per-requester access request; bit 0 = LSU, bit 1 = fetch.
REQ-007 SHALL have port rnw  in  2  per-requester read-not-write; 1 = read.
REQ-008 SHALL have port addr  in  2 x ADDRESS_SIZE  per-requester word address.
REQ-009 SHALL have port wdata  in  2 x WORD_SIZE  per-requester write data.
REQ-010 SHALL have port gnt  out  2  one-cycle pulse: request accepted.
REQ-011 SHALL have port done  out  2  one-cycle pulse: access complete.
REQ-012 SHALL have port err  out  2  one-cycle pulse with done: access timed out.
REQ-013 SHALL have port rdata  out  WORD_SIZE  read data, valid while done is high.
REQ-014 SHALL have port mem_enable  out  1  memory ENABLE.
REQ-015 SHALL have port mem_readnotwrite  out  1  memory READNOTWRITE.
REQ-016 SHALL have port mem_address  out  ADDRESS_SIZE  memory ADDRESS.
REQ-017 SHALL have port mem_wdata  out  WORD_SIZE  data driven toward the memory data bus on writes.
REQ-018 SHALL have port mem_rdata  in  WORD_SIZE  data returned by the memory on reads.
REQ-019 SHALL have port mem_data_ready  in  1  memory DATA_READY.

Function
REQ-020 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE; only one access is outstanding at a time.
REQ-021 In IDLE with any req bit high, SHALL select a winner per REQ-030, latch its rnw/addr/wdata, enter BUSY next cycle, and pulse gnt[winner] in that first BUSY cycle.
REQ-022 In BUSY, SHALL hold mem_enable=1 with the latched rnw/addr/wdata constant; requester input changes after latching SHALL be ignored.
REQ-023 In BUSY, when mem_data_ready=1 is sampled, SHALL capture mem_rdata (reads only) and enter DONE; mem_enable=0 from the DONE cycle onward.
REQ-024 In DONE, SHALL assert done[winner] for exactly one cycle with rdata valid, then return to IDLE; minimum issue spacing is 3 cycles.
REQ-025 SHALL count BUSY cycles in an 8-bit counter cleared on entry to BUSY; if the count reaches TIMEOUT_CYCLES without mem_data_ready, SHALL enter DONE with err[winner]=1 and rdata=0.
REQ-026 mem_data_ready sampled in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success (err=0).
REQ-027 For writes, rdata SHALL be 0 while done is high.
REQ-028 Requesters SHALL hold req until gnt; req dropped before gnt withdraws the request with no side effect.
REQ-029 gnt, done and err SHALL never be asserted for both requesters in the same cycle.

Arbitration
REQ-030 Default fixed priority: LSU (bit 0) wins over fetch (bit 1) on simultaneous requests in IDLE.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, counter=0, gnt=0, done=0, err=0, rdata=0, mem_enable=0, mem_readnotwrite=1, mem_address=0, mem_wdata=0, round-robin pointer=LSU.
REQ-032 Reset during BUSY SHALL abort the access silently: no done pulse, and mem_enable=0 in the cycle after the reset edge.

Configuration
REQ-033 With macro MEM_ARB_ROUND_ROBIN_EN defined, SHALL replace fixed priority with round-robin: the requester that did not win the last grant wins a simultaneous contest; the pointer updates on each gnt.
REQ-034 Without MEM_ARB_ROUND_ROBIN_EN, SHALL use fixed priority per REQ-030, and no pointer register SHALL exist.

Structure
REQ-035 SHALL place the FSM state enum typedef (IDLE/BUSY/DONE), NUM_REQ=2, LSU_IDX=0 and FETCH_IDX=1 in shared package mem_arb_pkg.
REQ-036 SHALL implement winner selection in a sub-module mem_arb_sel (inputs: req and pointer; output: one-hot grant); all other logic stays in mem_arbiter.

Verification
REQ-037 Single LSU read at addr 0x0010, memory ready after 2 cycles with 0xDEADBEEF -> gnt[0] in cycle 1, done[0] with rdata=0xDEADBEEF, err=0.
REQ-038 Fetch write of 0x12345678 to 0x0020 -> mem_enable=1, mem_readnotwrite=0, mem_wdata=0x12345678; done[1] with rdata=0.
REQ-039 Both requesters held high for 4 accesses -> fixed build: LSU, LSU, LSU, LSU; MEM_ARB_ROUND_ROBIN_EN build: LSU, fetch, LSU, fetch.
REQ-040 mem_data_ready tied low with TIMEOUT_CYCLES=16 -> done[0] and err[0] exactly 16 cycles after gnt, rdata=0, then return to IDLE.
REQ-041 rst asserted in the 2nd BUSY cycle of a read -> mem_enable=0 in the next cycle, no done or err; a fresh request afterward completes normally.
REQ-042 Requester changes addr from 0x0001 to 0x0002 after gnt -> mem_address stays 0x0001 for the whole access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and requester indices for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ   = 2;
    localparam int LSU_IDX   = 0;
    localparam int FETCH_IDX = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection: one-hot grant from the request vector; on a tie the
// requester named by ptr wins (ptr is tied to LSU in the fixed-priority build).
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (req[LSU_IDX] && req[FETCH_IDX])
            grant[ptr] = 1'b1;
        else if (req[LSU_IDX])
            grant[LSU_IDX] = 1'b1;
        else if (req[FETCH_IDX])
            grant[FETCH_IDX] = 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (LSU/fetch) single-outstanding memory arbiter with BUSY timeout.
// Define MEM_ARB_ROUND_ROBIN_EN to replace fixed LSU priority with round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [NUM_REQ-1:0]                      rnw,
    input  logic [NUM_REQ-1:0][ADDRESS_SIZE-1:0]    addr,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]       wdata,
    output logic [NUM_REQ-1:0]                      gnt,
    output logic [NUM_REQ-1:0]                      done,
    output logic [NUM_REQ-1:0]                      err,
    output logic [WORD_SIZE-1:0]                    rdata,
    output logic                                    mem_enable,
    output logic                                    mem_readnotwrite,
    output logic [ADDRESS_SIZE-1:0]                 mem_address,
    output logic [WORD_SIZE-1:0]                    mem_wdata,
    input  logic [WORD_SIZE-1:0]                    mem_rdata,
    input  logic                                    mem_data_ready
);

    // Counter holds BUSY cycles already elapsed, so the last allowed cycle sees TIMEOUT-1.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t              state, state_nxt;
    logic [7:0]          busy_cnt;
    logic [NUM_REQ-1:0]  sel_gnt;
    logic [NUM_REQ-1:0]  owner;
    logic                win_idx;
    logic                timeout_hit;
    logic                arb_ptr;

    assign win_idx     = sel_gnt[FETCH_IDX];
    assign timeout_hit = (busy_cnt == TO_LAST);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Points at the requester preferred on the next tie: the loser of the last grant.
    always_ff @(posedge clk) begin
        if (rst)
            arb_ptr <= 1'(LSU_IDX);
        else if (state == IDLE && |req)
            arb_ptr <= ~sel_gnt[FETCH_IDX];
    end
`else
    assign arb_ptr = 1'(LSU_IDX);
`endif

    mem_arb_sel u_sel (
        .req   (req),
        .ptr   (arb_ptr),
        .grant (sel_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = BUSY;
            BUSY:    if (mem_data_ready || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt              <= '0;
            done             <= '0;
            err              <= '0;
            rdata            <= '0;
            owner            <= '0;
            busy_cnt         <= '0;
            mem_enable       <= 1'b0;
            mem_readnotwrite <= 1'b1;
            mem_address      <= '0;
            mem_wdata        <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner            <= sel_gnt;
                        gnt              <= sel_gnt;
                        busy_cnt         <= '0;
                        mem_enable       <= 1'b1;
                        mem_readnotwrite <= rnw[win_idx];
                        mem_address      <= addr[win_idx];
                        mem_wdata        <= wdata[win_idx];
                    end
                end
                BUSY: begin
                    busy_cnt <= busy_cnt + 8'd1;
                    // A ready arriving on the last allowed cycle still wins over the timeout.
                    if (mem_data_ready || timeout_hit) begin
                        mem_enable <= 1'b0;
                        done       <= owner;
                        err        <= mem_data_ready ? '0 : owner;
                        rdata      <= (mem_data_ready && mem_readnotwrite) ? mem_rdata : '0;
                    end
                end
                DONE: rdata <= '0;
                default: ;
            endcase
        end
    end

endmodule
